// File: rtl/des_sbox_layer.sv
// rtl/des_sbox_layer.sv - DES S-box substitution layer, LANES boxes per cycle
module des_sbox_layer #(
    parameter int LANES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:48] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:32] out_data,
    output logic        busy
);

    // Only divisors of 8 give a whole number of groups per word.
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_lanes_check
        $error("des_sbox_layer: LANES must be 1, 2, 4 or 8");
    end

    localparam int GROUPS = 8 / LANES;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(GROUPS - 1);
    localparam logic [31:0]      SLOT_MASK = 32'hFFFF_FFFF << (32 - 4 * LANES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // S1..S8 packed S1 first; inside a box, entry row*16+col sits at nibble
    // position row*16+col counted from the most significant end.
    localparam logic [2047:0] SBOX_ROM = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Row is {b1,b6}, column is b2..b5; the bit offset of entry
    // box*64 + row*16 + col from the top of the ROM is its complement.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] chunk);
        logic [10:0] msb;
        msb = ~{box, chunk[5], chunk[0], chunk[4:1], 2'b00};
        return SBOX_ROM[msb -: 4];
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:48]      in_reg_q, in_reg_d;
    logic [1:32]      res_q, res_d;

    logic [6*LANES-1:0] grp_src;
    logic [4*LANES-1:0] lane_bits;
    logic [31:0]        lane_word;

    // The group being processed, left-aligned lane 0 at the top.
    assign grp_src = (6 * LANES)'(in_reg_q >> ((GROUPS - 1 - int'(cnt_q)) * 6 * LANES));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_bits[4*(LANES-1-l) +: 4] =
            sbox_lookup(3'(int'(cnt_q) * LANES + l), grp_src[6*(LANES-1-l) +: 6]);
    end

    assign lane_word = 32'(lane_bits) << (32 - 4 * LANES);

    // Next-state: accept in IDLE, fill one group of result fields per RUN cycle,
    // hold the result in DONE until the consumer takes it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_reg_d = in_reg_q;
        res_d    = res_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    in_reg_d = in_data;
                    res_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d = (res_q & ~(SLOT_MASK >> (int'(cnt_q) * 4 * LANES)))
                      | (lane_word >> (int'(cnt_q) * 4 * LANES));
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            in_reg_q <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in_reg_q <= in_reg_d;
            res_q    <= res_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign out_data  = res_q;

endmodule
